// File: rtl/frog_game_ctrl.sv
// Frog game controller: turns debounced switch presses into single hop pulses
// (with a hop cooldown), tracks lives and score, and sequences the game
// through idle, play, death/respawn and game-over.
//
// state | meaning
// IDLE  | waiting for any press to start a new game
// PLAY  | frog is live; hops, goals and collisions handled
// DEAD  | frog hit a hazard; respawn timer running, inputs ignored
// OVER  | no lives left; score/lives held until a press returns to IDLE
module frog_game_ctrl #(
   parameter int HOP_COOLDOWN  = 2500000,
   parameter int RESPAWN_DELAY = 12500000,
   parameter int START_LIVES   = 3
) (
   input  logic       i_Clk,
   input  logic       reset,
   input  logic       i_Switch_1,
   input  logic       i_Switch_2,
   input  logic       i_Switch_3,
   input  logic       i_Switch_4,
   input  logic       i_collision,
   input  logic       i_at_goal,
   output logic       o_move_up,
   output logic       o_move_down,
   output logic       o_move_left,
   output logic       o_move_right,
   output logic       o_frog_reset,
   output logic [1:0] o_state,
   output logic [1:0] o_lives,
   output logic [7:0] o_score
);

   localparam int CW = $clog2(HOP_COOLDOWN + 1);
   localparam int DW = $clog2(RESPAWN_DELAY + 1);

   localparam logic [CW-1:0] COOL_LOAD  = CW'(HOP_COOLDOWN);
   // The DEAD state lasts RESPAWN_DELAY cycles: the entry cycle plus the
   // countdown to zero, so the timer is loaded with one less.
   localparam logic [DW-1:0] DEAD_LOAD  = DW'(RESPAWN_DELAY - 1);
   localparam logic [1:0]    LIVES_LOAD = 2'(START_LIVES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DEAD = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   state_t        state;
   logic [3:0]    sw_cur;
   logic [3:0]    sw_prev;
   logic [3:0]    sw_edge;
   logic [CW-1:0] cooldown;
   logic [DW-1:0] dead_timer;

   // Switch vector order: {right, up, down, left}
   assign sw_cur  = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
   assign sw_edge = sw_cur & ~sw_prev;
   assign o_state = state;

   // Previous switch levels; reset high so a switch held through reset
   // does not look like a fresh press once reset is released.
   always_ff @(posedge i_Clk or posedge reset) begin
      if (reset) begin
         sw_prev <= 4'b1111;
      end else begin
         sw_prev <= sw_cur;
      end
   end

   // Game sequencer with registered hop/respawn pulses, lives, score and timers.
   always_ff @(posedge i_Clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         o_move_up    <= 1'b0;
         o_move_down  <= 1'b0;
         o_move_left  <= 1'b0;
         o_move_right <= 1'b0;
         o_frog_reset <= 1'b0;
         o_lives      <= 2'd0;
         o_score      <= 8'd0;
         cooldown     <= '0;
         dead_timer   <= '0;
      end else begin
         o_move_up    <= 1'b0;
         o_move_down  <= 1'b0;
         o_move_left  <= 1'b0;
         o_move_right <= 1'b0;
         o_frog_reset <= 1'b0;

         // Cooldown runs freely in every state; loads below take precedence.
         if (cooldown != '0) begin
            cooldown <= cooldown - CW'(1);
         end

         case (state)
            ST_IDLE: begin
               if (|sw_edge) begin
                  state        <= ST_PLAY;
                  o_frog_reset <= 1'b1;
                  o_lives      <= LIVES_LOAD;
                  o_score      <= 8'd0;
                  cooldown     <= '0;
               end
            end

            ST_PLAY: begin
               if (i_collision) begin
                  state      <= ST_DEAD;
                  dead_timer <= DEAD_LOAD;
                  if (o_lives != 2'd0) begin
                     o_lives <= o_lives - 2'd1;
                  end
               end else if (i_at_goal) begin
                  o_frog_reset <= 1'b1;
                  if (o_score != 8'hFF) begin
                     o_score <= o_score + 8'd1;
                  end
               end else if ((|sw_edge) && (cooldown == '0)) begin
                  cooldown <= COOL_LOAD;
                  // One hop per cycle: up > down > left > right.
                  if (sw_edge[2]) begin
                     o_move_up <= 1'b1;
                  end else if (sw_edge[1]) begin
                     o_move_down <= 1'b1;
                  end else if (sw_edge[0]) begin
                     o_move_left <= 1'b1;
                  end else begin
                     o_move_right <= 1'b1;
                  end
               end
            end

            ST_DEAD: begin
               if (dead_timer == '0) begin
                  if (o_lives == 2'd0) begin
                     state <= ST_OVER;
                  end else begin
                     state        <= ST_PLAY;
                     o_frog_reset <= 1'b1;
                     cooldown     <= '0;
                  end
               end else begin
                  dead_timer <= dead_timer - DW'(1);
               end
            end

            ST_OVER: begin
               if (|sw_edge) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
